calc_sequencer: RTL and testbench

Two-requester front end for the serial `calc` unit. It accepts whole operations `{op, a, b}` from two requesters over valid/ready handshakes and arbitrates between them round-robin. It serialises the granted operation onto calc's `validIn`/`dataIn` word protocol (operand, operator, optional second operand), then captures `dataOut` and returns it tagged with the requester id. It sits directly in front of one `calc` instance and is the only driver of that instance's `validIn`/`dataIn`.

---
 rtl/calc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: two-requester round-robin front end for one serial calc unit.
// A granted {op, a, b} is serialised as operand, operator, optional second
// operand on calc's validIn/dataIn word protocol. The result is taken from
// calc_dataOut and returned tagged with the requester id.
//
// Handshake rule (requests and responses alike): a transfer completes on a
// rising clk edge where valid and ready are both high. The producer holds
// valid and payload stable until that edge. Ready may depend combinationally
// on valid.
module calc_sequencer #(
   parameter int         W          = 16,
   parameter logic [7:0] UNARY_MASK = 8'b0000_1100,
   parameter int         RES_WAIT   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [2:0]   req_op0,
   input  logic [2:0]   req_op1,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_b1,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         busy,
   output logic         calc_validIn,
   output logic [W-1:0] calc_dataIn,
   input  logic [W-1:0] calc_dataOut,
   output logic [3:0]   dbg_state
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_A_S  = 4'd1;
   localparam logic [3:0] S_A_G  = 4'd2;
   localparam logic [3:0] S_O_S  = 4'd3;
   localparam logic [3:0] S_O_G  = 4'd4;
   localparam logic [3:0] S_B_S  = 4'd5;
   localparam logic [3:0] S_B_G  = 4'd6;
   localparam logic [3:0] S_WAIT = 4'd7;
   localparam logic [3:0] S_RESP = 4'd8;

   // Wait counter is loaded with RES_WAIT-1 and leaves WAIT when it reads zero.
   localparam int            CW        = (RES_WAIT > 1) ? $clog2(RES_WAIT) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'((RES_WAIT > 0) ? RES_WAIT - 1 : 0);
   localparam logic [3:0]    S_POST    = (RES_WAIT > 0) ? S_WAIT : S_RESP;
   localparam logic          CAP_AT_GAP = (RES_WAIT == 0);

   logic [3:0]    state_q, state_d;
   logic          last_q, last_d;
   logic          id_q, id_d;
   logic [2:0]    op_q, op_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  res_q, res_d;

   logic          grant;
   logic          win;
   logic          cap;
   logic          unary;

   assign unary = UNARY_MASK[op_q];

   // Arbitration: sole requester wins, a tie goes to the one not granted last.
   always_comb begin
      win       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      grant     = (state_q == S_IDLE) && (req_valid != 2'b00) && !rst;
      req_ready = 2'b00;
      if (grant) begin
         req_ready = win ? 2'b10 : 2'b01;
      end
   end

   // Next-state, wait counter and result-capture decision.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      case (state_q)
         S_IDLE: if (grant) state_d = S_A_S;
         S_A_S:  state_d = S_A_G;
         S_A_G:  state_d = S_O_S;
         S_O_S:  state_d = S_O_G;
         S_O_G: begin
            if (unary) begin
               state_d = S_POST;
               cnt_d   = WAIT_LOAD;
               cap     = CAP_AT_GAP;
            end else begin
               state_d = S_B_S;
            end
         end
         S_B_S:  state_d = S_B_G;
         S_B_G: begin
            state_d = S_POST;
            cnt_d   = WAIT_LOAD;
            cap     = CAP_AT_GAP;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               cap     = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, grant pointer and result capture.
   always_comb begin
      last_d = last_q;
      id_d   = id_q;
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      if (grant) begin
         last_d = win;
         id_d   = win;
         op_d   = win ? req_op1 : req_op0;
         a_d    = win ? req_a1  : req_a0;
         b_d    = win ? req_b1  : req_b0;
      end
      if (cap) begin
         res_d = calc_dataOut;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         op_q    <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Word driven to calc: gap states hold the word of the preceding strobe.
   always_comb begin
      calc_validIn = (state_q == S_A_S) || (state_q == S_O_S) || (state_q == S_B_S);
      case (state_q)
         S_A_S, S_A_G: calc_dataIn = a_q;
         S_O_S, S_O_G: calc_dataIn = {{(W-3){1'b0}}, op_q};
         S_B_S, S_B_G: calc_dataIn = b_q;
         default:      calc_dataIn = '0;
      endcase
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = res_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: drives calc_sequencer against a behavioural calc model,
// with a cycle-offset reference model of the sequencer checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_calc_sequencer;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT 0 (RES_WAIT = 0) ----------------
   logic [1:0]   req_valid = 2'b00;
   logic [1:0]   req_ready;
   logic [2:0]   op_r [2];
   logic [W-1:0] a_r  [2];
   logic [W-1:0] b_r  [2];
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         busy;
   logic         calc_validIn;
   logic [W-1:0] calc_dataIn;
   logic [W-1:0] calc_dataOut;
   logic [3:0]   dbg0;

   calc_sequencer #(.W(W), .RES_WAIT(0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(op_r[0]), .req_op1(op_r[1]),
      .req_a0(a_r[0]), .req_a1(a_r[1]),
      .req_b0(b_r[0]), .req_b1(b_r[1]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
      .calc_validIn(calc_validIn), .calc_dataIn(calc_dataIn),
      .calc_dataOut(calc_dataOut), .dbg_state(dbg0)
   );

   // ---------------- DUT 2 (RES_WAIT = 2) ----------------
   logic [1:0]   r2_valid = 2'b00;
   logic [1:0]   r2_ready;
   logic [2:0]   r2_op = 3'd0;
   logic [W-1:0] r2_a = '0;
   logic         rsp2_valid, rsp2_id, busy2, vin2;
   logic [W-1:0] rsp2_data, din2, dout2;
   logic [3:0]   dbg2;

   calc_sequencer #(.W(W), .RES_WAIT(2)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid(r2_valid), .req_ready(r2_ready),
      .req_op0(r2_op), .req_op1(3'd0),
      .req_a0(r2_a), .req_a1('0),
      .req_b0('0), .req_b1('0),
      .rsp_valid(rsp2_valid), .rsp_ready(1'b1),
      .rsp_id(rsp2_id), .rsp_data(rsp2_data), .busy(busy2),
      .calc_validIn(vin2), .calc_dataIn(din2),
      .calc_dataOut(dout2), .dbg_state(dbg2)
   );

   // ---------------- calc arithmetic ----------------
   function automatic logic [W-1:0] calc_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a * b;
         3'd2:    return a * a;
         3'd3:    return a + 1'b1;
         default: return '0;
      endcase
   endfunction

   function automatic bit unary_f(input logic [2:0] op);
      return (op == 3'd2) || (op == 3'd3);
   endfunction

   // ---------------- calc models (one per DUT) ----------------
   logic [1:0]   c0_cnt, c2_cnt;
   logic [W-1:0] c0_a, c2_a;
   logic [2:0]   c0_op, c2_op;

   always @(posedge clk) begin
      if (rst) begin
         c0_cnt <= 2'd0; calc_dataOut <= '0;
      end else if (calc_validIn) begin
         case (c0_cnt)
            2'd0: begin c0_a <= calc_dataIn; c0_cnt <= 2'd1; end
            2'd1: begin
               c0_op <= calc_dataIn[2:0];
               if (unary_f(calc_dataIn[2:0])) begin
                  calc_dataOut <= calc_fn(calc_dataIn[2:0], c0_a, '0);
                  c0_cnt <= 2'd0;
               end else c0_cnt <= 2'd2;
            end
            default: begin calc_dataOut <= calc_fn(c0_op, c0_a, calc_dataIn); c0_cnt <= 2'd0; end
         endcase
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         c2_cnt <= 2'd0; dout2 <= '0;
      end else if (vin2) begin
         case (c2_cnt)
            2'd0: begin c2_a <= din2; c2_cnt <= 2'd1; end
            2'd1: begin
               c2_op <= din2[2:0];
               if (unary_f(din2[2:0])) begin
                  dout2 <= calc_fn(din2[2:0], c2_a, '0);
                  c2_cnt <= 2'd0;
               end else c2_cnt <= 2'd2;
            end
            default: begin dout2 <= calc_fn(c2_op, c2_a, din2); c2_cnt <= 2'd0; end
         endcase
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_msg(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Reference model: a granted operation is tracked as an offset from its
   // grant cycle; outputs follow from that offset and the opcode arity.
   bit           m_act  = 1'b0;
   bit           m_last = 1'b1;
   int           m_t, m_n;
   bit           m_id;
   logic [2:0]   m_op;
   logic [W-1:0] m_a, m_b, m_res;
   logic [1:0]   e_ready;
   bit           e_vin, e_rv, din_chk, e_win;
   logic [W-1:0] e_din;

   always @(negedge clk) begin
      if (chk_en) begin
         e_ready = 2'b00; e_vin = 1'b0; e_din = '0; e_rv = 1'b0; din_chk = 1'b1;
         m_n = 0;
         if (m_act) begin
            m_n   = unary_f(m_op) ? 5 : 7;
            e_vin = (m_t == 1) || (m_t == 3) || (m_t == 5 && !unary_f(m_op));
            if (m_t <= 2)      e_din = m_a;
            else if (m_t <= 4) e_din = {{(W-3){1'b0}}, m_op};
            else               e_din = m_b;
            din_chk = (m_t < m_n);
            e_rv    = (m_t >= m_n);
         end else if (!rst && req_valid != 2'b00) begin
            e_win   = (req_valid == 2'b11) ? !m_last : req_valid[1];
            e_ready = e_win ? 2'b10 : 2'b01;
         end
         check("req_ready", req_ready, e_ready);
         check("calc_validIn", calc_validIn, e_vin);
         check("busy", busy, m_act);
         check("rsp_valid", rsp_valid, e_rv);
         if (din_chk) check("calc_dataIn", calc_dataIn, e_din);
         if (e_rv) begin
            check("rsp_data", rsp_data, m_res);
            check("rsp_id", rsp_id, m_id);
         end
         if (rst) begin
            m_act = 1'b0; m_last = 1'b1;
         end else if (m_act) begin
            if (e_rv && rsp_ready) m_act = 1'b0;
            else m_t++;
         end else if (e_ready != 2'b00) begin
            m_act = 1'b1; m_t = 1; m_id = e_win; m_last = e_win;
            m_op = op_r[e_win]; m_a = a_r[e_win]; m_b = b_r[e_win];
            m_res = calc_fn(m_op, m_a, m_b);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      int guard;
      @(posedge clk); #1;
      op_r[id] = op; a_r[id] = a; b_r[id] = b; req_valid[id] = 1'b1;
      for (guard = 0; guard < 50; guard++) begin
         @(negedge clk); #1;
         if (req_ready[id]) break;
         @(posedge clk); #1;
      end
      if (guard == 50) fail_msg("grant_timeout");
   endtask

   task automatic run_op(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res);
      int n;
      n = unary_f(op) ? 5 : 7;
      issue(id, op, a, b);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == 1) req_valid[id] = 1'b0;
         @(negedge clk); #1;
         if (k == 1) begin check("lit_strobe_a", calc_validIn, 1); check("lit_word_a", calc_dataIn, a); end
         if (k == 3) begin check("lit_strobe_op", calc_validIn, 1); check("lit_word_op", calc_dataIn, 32'(op)); end
         if (k == 5 && n == 7) begin check("lit_strobe_b", calc_validIn, 1); check("lit_word_b", calc_dataIn, b); end
         if (k == n - 1) check("lit_rsp_early", rsp_valid, 0);
         if (k == n) begin
            check("lit_rsp_valid", rsp_valid, 1);
            check("lit_rsp_data", rsp_data, exp_res);
            check("lit_rsp_id", rsp_id, id);
         end
      end
   endtask

   // ---------------- scoreboard for contention ----------------
   logic [W:0] exp_q [$];
   logic [W:0] got_e;
   logic [1:0] acc;

   initial begin
      int guard;
      for (int i = 0; i < 2; i++) begin op_r[i] = 3'd0; a_r[i] = '0; b_r[i] = '0; end

      // Reset and reset values.
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk); #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_validIn", calc_validIn, 0);
      check("rst_dataIn", calc_dataIn, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Unary square of 2 from requester 0, binary 7*6 from requester 1.
      run_op(0, 3'd2, 16'd2, 16'd0, 16'd4);
      run_op(1, 3'd1, 16'd7, 16'd6, 16'd42);

      // Contention: both valid every cycle, alternating grants.
      @(posedge clk); #1;
      op_r[0] = 3'd0; a_r[0] = 16'd3; b_r[0] = 16'd4;
      op_r[1] = 3'd3; a_r[1] = 16'd9; b_r[1] = 16'd0;
      req_valid = 2'b11;
      exp_q.push_back({1'b0, 16'd7});
      exp_q.push_back({1'b1, 16'd10});
      exp_q.push_back({1'b0, 16'd7});
      exp_q.push_back({1'b1, 16'd10});
      for (guard = 0; guard < 100 && exp_q.size() > 0; guard++) begin
         @(negedge clk); #1;
         if (rsp_valid && rsp_ready) begin
            got_e = exp_q.pop_front();
            check("cont_id", rsp_id, got_e[W]);
            check("cont_data", rsp_data, got_e[W-1:0]);
         end
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      check("cont_remaining", exp_q.size(), 0);

      // Backpressure: result held in RESP while the consumer stalls.
      rsp_ready = 1'b0;
      issue(0, 3'd0, 16'd3, 16'd4);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      op_r[1] = 3'd3; a_r[1] = 16'd9; req_valid[1] = 1'b1;
      for (guard = 0; guard < 20; guard++) begin
         @(negedge clk); #1;
         if (rsp_valid) break;
         @(posedge clk); #1;
      end
      if (guard == 20) fail_msg("bp_rsp_timeout");
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_data", rsp_data, 7);
         check("bp_rsp_id", rsp_id, 0);
         check("bp_validIn", calc_validIn, 0);
         check("bp_req_ready", req_ready, 0);
         @(posedge clk); #1;
         @(negedge clk); #1;
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      for (guard = 0; guard < 20; guard++) begin
         @(negedge clk); #1;
         if (req_ready[1]) break;
         @(posedge clk); #1;
      end
      if (guard == 20) fail_msg("bp_grant1_timeout");
      @(posedge clk); #1 req_valid[1] = 1'b0;
      repeat (8) @(posedge clk);

      // Reset while the second operand is being strobed.
      issue(1, 3'd1, 16'd5, 16'd5);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k == 1) req_valid[1] = 1'b0;
         if (k == 5) rst = 1'b1;
      end
      @(negedge clk); #1;
      check("rstmid_strobe_b", calc_validIn, 1);
      check("rstmid_word_b", calc_dataIn, 5);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      check("rstmid_validIn", calc_validIn, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_rsp_valid", rsp_valid, 0);
      run_op(0, 3'd2, 16'd3, 16'd0, 16'd9);

      // Randomized traffic, consumer stalls and occasional resets.
      acc = 2'b00;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               op_r[i] = 3'($urandom_range(0, 3));
               a_r[i]  = W'($urandom_range(0, 16'hffff));
               b_r[i]  = W'($urandom_range(0, 16'hffff));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk); #1;
         acc = req_ready & req_valid;
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
      repeat (20) @(posedge clk);

      // RES_WAIT = 2 instance: increment of 5.
      @(posedge clk); #1;
      r2_op = 3'd3; r2_a = 16'd5; r2_valid = 2'b01;
      for (guard = 0; guard < 20; guard++) begin
         @(negedge clk); #1;
         if (r2_ready[0]) break;
         @(posedge clk); #1;
      end
      if (guard == 20) fail_msg("rw2_grant_timeout");
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 1) r2_valid = 2'b00;
         @(negedge clk); #1;
         if (k == 1) begin check("rw2_strobe_a", vin2, 1); check("rw2_word_a", din2, 5); end
         if (k == 3) begin check("rw2_strobe_op", vin2, 1); check("rw2_word_op", din2, 3); end
         if (k == 5) check("rw2_no_third", vin2, 0);
         if (k == 6) check("rw2_rsp_early", rsp2_valid, 0);
         if (k == 7) begin
            check("rw2_rsp_valid", rsp2_valid, 1);
            check("rw2_rsp_data", rsp2_data, 6);
            check("rw2_rsp_id", rsp2_id, 0);
         end
      end
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
